// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: IDLE/RUN/PAUSE FSM driving a programmable tick divider
// and a wrapping min:sec counter with a sticky overflow flag.
module stopwatch_ctrl #(
   parameter int unsigned SEC_MAX = 59,
   parameter int unsigned MIN_MAX = 59
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] num,
   input  logic        btn_start,
   input  logic        btn_clear,
   output logic        tick,
   output logic [5:0]  sec,
   output logic [5:0]  min,
   output logic        running,
   output logic        ovf
);

   localparam logic [5:0] SEC_TOP = 6'(SEC_MAX);
   localparam logic [5:0] MIN_TOP = 6'(MIN_MAX);

   typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

   state_t      state, state_n;
   logic [31:0] div;
   logic [31:0] div_lim;
   logic        tick_hit;
   logic        enter_idle;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   // btn_clear is checked first everywhere so it wins over btn_start
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (btn_start && !btn_clear) state_n = RUN;
         RUN:     if (btn_clear) state_n = IDLE;
                  else if (btn_start) state_n = PAUSE;
         PAUSE:   if (btn_clear) state_n = IDLE;
                  else if (btn_start) state_n = RUN;
         default: state_n = IDLE;
      endcase
   end

   // num of 0 or 1 both mean a tick every cycle; >= lets a lowered num fire at once
   always_comb begin
      div_lim    = (num > 32'd1) ? (num - 32'd1) : '0;
      tick_hit   = (state == RUN) && (div >= div_lim);
      enter_idle = (state != IDLE) && btn_clear;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div     <= '0;
         tick    <= 1'b0;
         sec     <= '0;
         min     <= '0;
         ovf     <= 1'b0;
         running <= 1'b0;
      end else begin
         running <= (state == RUN);
         if (enter_idle) begin
            div  <= '0;
            tick <= 1'b0;
            sec  <= '0;
            min  <= '0;
            ovf  <= 1'b0;
         end else if (tick_hit) begin
            div  <= '0;
            tick <= 1'b1;
            if (sec < SEC_TOP) begin
               sec <= sec + 6'd1;
            end else begin
               sec <= '0;
               if (min < MIN_TOP) begin
                  min <= min + 6'd1;
               end else begin
                  min <= '0;
                  ovf <= 1'b1;
               end
            end
         end else begin
            tick <= 1'b0;
            if (state == RUN) div <= div + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: constant vector table, directed corner sequences,
// and randomized button/num traffic against a total-seconds reference model.
module tb_stopwatch_ctrl;

   localparam int unsigned SM = 59;
   localparam int unsigned MM = 59;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] num = '0;
   logic        btn_start = 1'b0;
   logic        btn_clear = 1'b0;
   logic        tick;
   logic [5:0]  sec;
   logic [5:0]  min;
   logic        running;
   logic        ovf;

   int compared   = 0;
   int mismatched = 0;

   stopwatch_ctrl #(.SEC_MAX(SM), .MIN_MAX(MM)) dut (
      .clk(clk), .rst(rst), .num(num), .btn_start(btn_start), .btn_clear(btn_clear),
      .tick(tick), .sec(sec), .min(min), .running(running), .ovf(ovf)
   );

   always #5 clk = ~clk;

   // reference model: elapsed seconds since last clear, plus tick phase
   bit              m_active, m_run, m_tick, m_running;
   longint unsigned m_total;
   int unsigned     m_phase;

   function automatic void model_edge(bit r, bit s, bit c, logic [31:0] n);
      longint unsigned lim;
      bit was_run;
      was_run = m_run;
      m_tick  = 1'b0;
      if (r) begin
         m_active = 0; m_run = 0; m_total = 0; m_phase = 0; m_running = 0;
         return;
      end
      m_running = was_run;
      if (c && m_active) begin
         m_active = 0; m_run = 0; m_total = 0; m_phase = 0;
         return;
      end
      if (m_run) begin
         lim = (n < 2) ? 0 : longint'(n) - 1;
         if (longint'(m_phase) >= lim) begin
            m_phase = 0; m_tick = 1'b1; m_total++;
         end else begin
            m_phase++;
         end
      end
      if (s && !c) begin
         if (!m_active) begin m_active = 1; m_run = 1; end
         else m_run = !m_run;
      end
   endfunction

   function automatic logic [14:0] model_out();
      longint unsigned ms, mm;
      bit mo;
      ms = m_total % (SM + 1);
      mm = (m_total / (SM + 1)) % (MM + 1);
      mo = (m_total >= longint'(SM + 1) * longint'(MM + 1));
      return {m_tick, ms[5:0], mm[5:0], m_running, mo};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input bit r, input bit s, input bit c, input logic [31:0] n);
      @(negedge clk);
      rst = r; btn_start = s; btn_clear = c; num = n;
      @(posedge clk);
      #1;
      model_edge(r, s, c, n);
      check("model", {tick, sec, min, running, ovf}, model_out());
   endtask

   typedef struct {
      bit          r, s, c;
      logic [31:0] n;
      bit          t;
      logic [5:0]  sc, mn;
      bit          rn, ov;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(bit r, bit s, bit c, logic [31:0] n,
                               bit t, logic [5:0] sc, logic [5:0] mn, bit rn, bit ov);
      vec_t v;
      v.r = r; v.s = s; v.c = c; v.n = n;
      v.t = t; v.sc = sc; v.mn = mn; v.rn = rn; v.ov = ov;
      tbl.push_back(v);
   endfunction

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int ticks;
      bit r, s, c;
      logic [31:0] n;

      // r s c num | tick sec min running ovf
      add(1,0,0,4, 0,0,0,0,0);
      add(0,1,0,4, 0,0,0,0,0);
      add(0,0,0,4, 0,0,0,1,0);
      add(0,0,0,4, 0,0,0,1,0);
      add(0,0,0,4, 0,0,0,1,0);
      add(0,0,0,4, 1,1,0,1,0);
      add(0,0,0,4, 0,1,0,1,0);
      add(0,0,0,4, 0,1,0,1,0);
      add(0,0,0,4, 0,1,0,1,0);
      add(0,0,0,4, 1,2,0,1,0);
      add(0,1,1,4, 0,0,0,1,0);
      add(0,0,0,4, 0,0,0,0,0);
      add(0,0,1,4, 0,0,0,0,0);
      add(0,1,0,0, 0,0,0,0,0);
      add(0,0,0,0, 1,1,0,1,0);
      add(0,0,0,0, 1,2,0,1,0);
      add(1,1,0,0, 0,0,0,0,0);
      add(0,0,0,0, 0,0,0,0,0);
      add(0,1,0,1, 0,0,0,0,0);
      add(0,1,0,1, 1,1,0,1,0);
      add(0,0,0,1, 0,1,0,0,0);
      add(0,1,0,1, 0,1,0,0,0);
      add(0,0,0,1, 1,2,0,1,0);

      foreach (tbl[i]) begin
         drive(tbl[i].r, tbl[i].s, tbl[i].c, tbl[i].n);
         check($sformatf("tbl[%0d]", i), {tick, sec, min, running, ovf},
               {tbl[i].t, tbl[i].sc, tbl[i].mn, tbl[i].rn, tbl[i].ov});
      end

      // 120 ticks at num=2: minute carry at tick 60 and 120
      drive(1,0,0,2);
      drive(0,1,0,2);
      ticks = 0;
      for (int i = 0; i < 1000 && ticks < 120; i++) begin
         drive(0,0,0,2);
         if (tick) begin
            ticks++;
            if (ticks == 59) check("tick59", {min, sec}, {6'd0, 6'd59});
            if (ticks == 60) check("wrap60", {min, sec}, {6'd1, 6'd0});
         end
      end
      check("ticks120_count", ticks, 120);
      check("tick120", {min, sec}, {6'd2, 6'd0});

      // pause holds the divider phase
      drive(1,0,0,5);
      drive(0,1,0,5);
      drive(0,0,0,5);
      drive(0,0,0,5);
      drive(0,1,0,5);
      ticks = 0;
      repeat (10) begin
         drive(0,0,0,5);
         if (tick) ticks++;
      end
      check("pause_no_tick", ticks, 0);
      check("pause_running", running, 0);
      drive(0,1,0,5);
      check("resume_edge_tick", tick, 0);
      drive(0,0,0,5);
      check("resume_plus1_tick", tick, 0);
      drive(0,0,0,5);
      check("resume_plus2_tick", {tick, sec}, {1'b1, 6'd1});

      // full wrap past 59:59 sets sticky ovf
      drive(1,0,0,1);
      drive(0,1,0,1);
      ticks = 0;
      for (int i = 0; i < 5000 && ticks < 3600; i++) begin
         drive(0,0,0,1);
         if (tick) begin
            ticks++;
            if (ticks == 3599) check("pre_wrap", {sec, min, ovf}, {6'd59, 6'd59, 1'b0});
         end
      end
      check("ticks3600_count", ticks, 3600);
      check("wrap3600", {sec, min, ovf}, {6'd0, 6'd0, 1'b1});
      drive(0,0,0,1);
      check("ovf_sticky", {sec, ovf}, {6'd1, 1'b1});
      drive(0,0,1,1);
      check("clear_ovf", {tick, sec, min, ovf}, 0);
      drive(0,0,0,1);
      check("clear_idle", {tick, running}, 0);

      // simultaneous start+clear in RUN at sec=7
      drive(1,0,0,1);
      drive(0,1,0,1);
      for (int i = 0; i < 20 && sec != 6'd7; i++) drive(0,0,0,1);
      check("sec7", sec, 7);
      drive(0,1,1,1);
      check("both_btn", {tick, sec}, 0);
      drive(0,0,0,1);
      check("both_btn_next", {running, sec, tick}, 0);

      // lowering num below div fires next edge; rst aborts
      drive(1,0,0,100);
      drive(0,1,0,100);
      repeat (50) drive(0,0,0,100);
      check("div50_no_tick", {tick, sec}, 0);
      drive(0,0,0,10);
      check("num_drop_tick", {tick, sec}, {1'b1, 6'd1});
      ticks = 0;
      repeat (9) begin
         drive(0,0,0,10);
         if (tick) ticks++;
      end
      check("num10_gap", ticks, 0);
      drive(0,0,0,10);
      check("num10_tick", {tick, sec}, {1'b1, 6'd2});
      drive(1,0,0,10);
      check("rst_cycle", {tick, sec, min, running, ovf}, 0);
      drive(0,0,0,10);
      check("rst_after", {tick, sec, min, running, ovf}, 0);

      // randomized traffic against the model
      drive(1,0,0,3);
      for (int i = 0; i < 4000; i++) begin
         r = ($urandom_range(0, 299) == 0);
         s = ($urandom_range(0, 11) == 0);
         c = ($urandom_range(0, 39) == 0);
         n = ($urandom_range(0, 49) == 0) ? 32'($urandom_range(0, 40))
                                          : 32'($urandom_range(0, 6));
         drive(r, s, c, n);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter SEC_MAX, default 59: terminal value of the seconds field.
REQ-002 Parameter MIN_MAX, default 59: terminal value of the minutes field.
REQ-003 clk  input  1: single system clock; all state updates on rising edge.
REQ-004 rst  input  1: reset, synchronous, active-high.
REQ-005 num  input  32: tick divisor, in clk cycles per tick.
REQ-006 btn_start  input  1: one-cycle pulse; toggles run/pause.
REQ-007 btn_clear  input  1: one-cycle pulse; returns to idle and zeroes all counts.
REQ-008 tick  output  1: one-cycle strobe marking each counted second.
REQ-009 sec  output  6: seconds count, 0..SEC_MAX.
REQ-010 min  output  6: minutes count, 0..MIN_MAX.
REQ-011 running  output  1: high while in RUN.
REQ-012 ovf  output  1: sticky flag, set on wrap past MIN_MAX:SEC_MAX.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and PAUSE.
REQ-014 IDLE: btn_start -> RUN; btn_clear is a no-op.
REQ-015 RUN: btn_start -> PAUSE; btn_clear -> IDLE.
REQ-016 PAUSE: btn_start -> RUN; btn_clear -> IDLE.
REQ-017 If btn_start and btn_clear are high in the same cycle, btn_clear SHALL win in every state.
REQ-018 Entering IDLE (any path) SHALL, at that same edge, zero sec, min, ovf, tick and the internal 32-bit divider count div.
REQ-019 In RUN, div SHALL increment by 1 per cycle.
- At an edge where div >= eff-1 (eff = num, or 1 if num is 0 or 1): div <= 0 and tick <= 1.
- At all other edges: tick <= 0.
REQ-020 The >= compare SHALL ensure that lowering num mid-run below the current div produces a tick on the next edge, never a 2^32 rollover.
REQ-021 In PAUSE, div, sec and min SHALL hold and tick SHALL be 0; resuming continues from the held div phase.
REQ-022 The edge that sets tick SHALL also update the count. The new sec/min value is visible in the same cycle that tick is high.
REQ-023 Count update on each tick:
- sec < SEC_MAX: sec+1.
- else: sec <= 0 and the minute field advances.
- minute advance: min < MIN_MAX: min+1; else min <= 0 and ovf <= 1.
REQ-024 ovf SHALL stay set until btn_clear or rst. Counting SHALL continue normally after the wrap.
REQ-025 running SHALL be a registered decode of state == RUN. It is valid in the cycle after the transition edge.
REQ-026 A btn_start pulse SHALL cause at most one transition. Level-high btn_start SHALL toggle once per cycle; no debouncing is performed in this block.
REQ-027 num SHALL be sampled every cycle; no latching at start.
REQ-028 sec and min SHALL never exceed SEC_MAX and MIN_MAX; all arithmetic is unsigned.

Reset
REQ-029 When rst is high at an edge: state <= IDLE; sec, min, tick, ovf, running and div <= 0.
REQ-030 rst SHALL take priority over btn_start and btn_clear.
REQ-031 rst asserted mid-RUN SHALL abort immediately. No tick SHALL be emitted in the reset cycle or in the first cycle after it.

Verification
REQ-032 num=4, rst then btn_start at cycle 0 -> running=1 from cycle 1; tick at cycles 4, 8, 12; sec=1, 2, 3 coincident with each tick.
REQ-033 num=2, run 120 ticks -> sec wraps 59->0 and min 0->1 on the tick 60 edge; min=2, sec=0 after tick 120.
REQ-034 num=5, btn_start; pause after 3 cycles; hold 10 cycles; resume -> no tick during the pause; first tick 2 cycles after resume.
REQ-035 num=1, SEC_MAX=MIN_MAX=59, run 3600 ticks -> sec=0, min=0, ovf=1 at tick 3600; btn_clear -> ovf=0, state IDLE.
REQ-036 btn_start and btn_clear in the same cycle while in RUN with sec=7 -> IDLE, sec=0, running=0 the next cycle.
REQ-037 num=100 while div=50 in RUN, then num changed to 10 -> tick on the next edge; next tick 10 cycles later; rst mid-run -> all outputs 0, tick=0 for 2 cycles.
